// File: rtl/vga_scanout.sv
// VGA beam generator and N-layer priority compositor; pixels for beam (x,y) emerge 2 cycles later.
// Free-running timing, no backpressure; layers answer the beam one cycle after it is presented.
module vga_scanout #(
  parameter int          H_VISIBLE = 800,
  parameter int          H_FRONT   = 56,
  parameter int          H_SYNC    = 120,
  parameter int          H_BACK    = 64,
  parameter int          V_VISIBLE = 600,
  parameter int          V_FRONT   = 37,
  parameter int          V_SYNC    = 6,
  parameter int          V_BACK    = 23,
  parameter int          SYNC_POL  = 1,
  parameter int          N_LAYERS  = 4,
  parameter logic [11:0] BG_COLOR  = 12'hFFF
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [10:0]                   beam_x,
  output logic [9:0]                    beam_y,
  input  logic [N_LAYERS-1:0][2:0][3:0] layer_color,
  input  logic [N_LAYERS-1:0]           layer_transparent,
  output logic [3:0]                    vga_r,
  output logic [3:0]                    vga_g,
  output logic [3:0]                    vga_b,
  output logic                          vga_hs,
  output logic                          vga_vs,
  output logic                          frame_start
);

  localparam logic [10:0] H_LAST   = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [10:0] H_ACT    = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_ACT    = 10'(V_VISIBLE);
  localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic        SYNC_ON  = (SYNC_POL != 0);

  logic        act_raw, hs_raw, vs_raw;
  logic        act_d1, hs_d1, vs_d1;
  logic        act_d2, hs_d2, vs_d2;
  logic [11:0] pix_sel, pix_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      beam_x <= '0;
      beam_y <= '0;
    end else if (beam_x == H_LAST) begin
      beam_x <= '0;
      beam_y <= (beam_y == V_LAST) ? 10'd0 : beam_y + 10'd1;
    end else begin
      beam_x <= beam_x + 11'd1;
    end
  end

  assign act_raw     = (beam_x < H_ACT) && (beam_y < V_ACT);
  assign hs_raw      = ((beam_x >= HS_START) && (beam_x < HS_END)) ? SYNC_ON : ~SYNC_ON;
  assign vs_raw      = ((beam_y >= VS_START) && (beam_y < VS_END)) ? SYNC_ON : ~SYNC_ON;
  assign frame_start = (beam_x == 11'd0) && (beam_y == 10'd0);

  // Walk from the bottom layer upward so the lowest opaque index wins.
  always_comb begin
    pix_sel = BG_COLOR;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (!layer_transparent[i]) pix_sel = layer_color[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_d1 <= 1'b0;
      hs_d1  <= ~SYNC_ON;
      vs_d1  <= ~SYNC_ON;
      act_d2 <= 1'b0;
      hs_d2  <= ~SYNC_ON;
      vs_d2  <= ~SYNC_ON;
      pix_q  <= '0;
    end else begin
      act_d1 <= act_raw;
      hs_d1  <= hs_raw;
      vs_d1  <= vs_raw;
      act_d2 <= act_d1;
      hs_d2  <= hs_d1;
      vs_d2  <= vs_d1;
      pix_q  <= pix_sel;
    end
  end

  assign vga_r  = act_d2 ? pix_q[11:8] : 4'd0;
  assign vga_g  = act_d2 ? pix_q[7:4]  : 4'd0;
  assign vga_b  = act_d2 ? pix_q[3:0]  : 4'd0;
  assign vga_hs = hs_d2;
  assign vga_vs = vs_d2;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a reduced raster: random layers vs. reference model, vector table, mid-frame reset.
module tb_vga_scanout;

  localparam int HV = 20, HF = 4, HS = 6, HB = 4;
  localparam int VV = 12, VF = 2, VS = 3, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int NCYC = 3 * FRAME;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [3:0][2:0][3:0]  layer_color = '0;
  logic [3:0]            layer_transparent = '1;
  logic [10:0]           beam_x, beam_x2;
  logic [9:0]            beam_y, beam_y2;
  logic [3:0]            vga_r, vga_g, vga_b, vga_r2, vga_g2, vga_b2;
  logic                  vga_hs, vga_vs, frame_start, vga_hs2, vga_vs2, frame_start2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vga_scanout #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                .SYNC_POL(1), .N_LAYERS(4), .BG_COLOR(12'hFFF)) dut (
    .clk(clk), .rst(rst), .beam_x(beam_x), .beam_y(beam_y),
    .layer_color(layer_color), .layer_transparent(layer_transparent),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start));

  vga_scanout #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                .SYNC_POL(0), .N_LAYERS(4), .BG_COLOR(12'hFFF)) dut_neg (
    .clk(clk), .rst(rst), .beam_x(beam_x2), .beam_y(beam_y2),
    .layer_color(layer_color), .layer_transparent(layer_transparent),
    .vga_r(vga_r2), .vga_g(vga_g2), .vga_b(vga_b2),
    .vga_hs(vga_hs2), .vga_vs(vga_vs2), .frame_start(frame_start2));

  typedef struct {
    int          x;
    int          y;
    logic [3:0]  tr;
    logic [47:0] col;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t        vecs [8];
  logic [47:0] hcol [NCYC];
  logic [3:0]  htr  [NCYC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: first opaque layer from the top, else background.
  function automatic logic [11:0] composite(input logic [47:0] col, input logic [3:0] tr);
    for (int i = 0; i < 4; i++) if (!tr[i]) return col[i*12 +: 12];
    return 12'hFFF;
  endfunction

  function automatic logic sync_lvl(input int pos, input int start, input int width, input logic pol);
    return (pos >= start && pos < start + width) ? pol : ~pol;
  endfunction

  task automatic wait_beam(input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < FRAME + 4; n++) begin
      @(negedge clk);
      if (beam_x == 11'(x) && beam_y == 10'(y)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL wait_beam(%0d,%0d): beam never reached, last (%0d,%0d)", x, y, beam_x, beam_y);
    end
  endtask

  initial begin
    int  fs_cnt, hs_cnt, vs_cnt, hs2_cnt, vs2_cnt;
    bit  ok;
    logic [63:0] got, exp;

    vecs[0] = '{10, 10, 4'b0001, {12'h000, 12'h0F0, 12'hF00, 12'h00F}, 12'hF00};
    vecs[1] = '{5,  5,  4'b1111, {12'h123, 12'h456, 12'h789, 12'hABC}, 12'hFFF};
    vecs[2] = '{25, 5,  4'b1111, {12'h123, 12'h456, 12'h789, 12'hABC}, 12'h000};
    vecs[3] = '{3,  3,  4'b0000, {12'h999, 12'h888, 12'h777, 12'h123}, 12'h123};
    vecs[4] = '{7,  2,  4'b1011, {12'h555, 12'hABC, 12'h333, 12'h444}, 12'hABC};
    vecs[5] = '{19, 11, 4'b0111, {12'h5A5, 12'h111, 12'h222, 12'h333}, 12'h5A5};
    vecs[6] = '{20, 11, 4'b0000, {12'h5A5, 12'h111, 12'h222, 12'h333}, 12'h000};
    vecs[7] = '{0,  12, 4'b0000, {12'h5A5, 12'h111, 12'h222, 12'h333}, 12'h000};

    // Reset state
    layer_transparent = 4'b0000;
    layer_color = 48'hEEE_EEE_EEE_EEE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_beam_x", 64'(beam_x), 64'd0);
    check("rst_beam_y", 64'(beam_y), 64'd0);
    check("rst_rgb", 64'({vga_r, vga_g, vga_b}), 64'd0);
    check("rst_sync_pos", 64'({vga_hs, vga_vs}), 64'b00);
    check("rst_sync_neg", 64'({vga_hs2, vga_vs2}), 64'b11);

    // Randomized run over three frames; cycle k=0 is the first cycle with rst low.
    @(posedge clk);
    #1 rst = 1'b0;
    fs_cnt = 0; hs_cnt = 0; vs_cnt = 0; hs2_cnt = 0; vs2_cnt = 0;
    for (int k = 0; k < NCYC; k++) begin
      int bx, by, px, py;
      logic [11:0] rgb;
      logic hs1, vs1, hsn, vsn;
      layer_color = {16'($urandom), 32'($urandom)};
      layer_transparent = 4'($urandom_range(0, 15));
      hcol[k] = layer_color;
      htr[k]  = layer_transparent;
      bx = k % HT;
      by = (k / HT) % VT;
      if (k < 2) begin
        rgb = 12'h000; hs1 = 1'b0; vs1 = 1'b0; hsn = 1'b1; vsn = 1'b1;
      end else begin
        px = (k - 2) % HT;
        py = ((k - 2) / HT) % VT;
        rgb = (px < HV && py < VV) ? composite(hcol[k-1], htr[k-1]) : 12'h000;
        hs1 = sync_lvl(px, HV + HF, HS, 1'b1);
        vs1 = sync_lvl(py, VV + VF, VS, 1'b1);
        hsn = sync_lvl(px, HV + HF, HS, 1'b0);
        vsn = sync_lvl(py, VV + VF, VS, 1'b0);
      end
      exp = 64'({11'(bx), 10'(by), (bx == 0 && by == 0), rgb, hs1, vs1, hsn, vsn});
      @(negedge clk);
      got = 64'({beam_x, beam_y, frame_start, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_hs2, vga_vs2});
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL cycle %0d: got %h, expected %h", k, got, exp);
      end
      fs_cnt  += int'(frame_start);
      hs_cnt  += int'(vga_hs);
      vs_cnt  += int'(vga_vs);
      hs2_cnt += int'(!vga_hs2);
      vs2_cnt += int'(!vga_vs2);
      @(posedge clk);
      #1;
    end
    check("frame_start_count", 64'(fs_cnt), 64'd3);
    check("hs_active_cycles", 64'(hs_cnt), 64'(3 * VT * HS));
    check("vs_active_cycles", 64'(vs_cnt), 64'(3 * VS * HT));
    check("hs_low_cycles_neg", 64'(hs2_cnt), 64'(3 * VT * HS));
    check("vs_low_cycles_neg", 64'(vs2_cnt), 64'(3 * VS * HT));

    // Table: layers stimulated in the cycle after beam (x,y), colour checked one cycle later.
    foreach (vecs[i]) begin
      wait_beam(vecs[i].x, vecs[i].y, ok);
      if (ok) begin
        @(posedge clk);
        #1;
        layer_color = vecs[i].col;
        layer_transparent = vecs[i].tr;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("vec%0d_rgb(%0d,%0d)", i, vecs[i].x, vecs[i].y),
              64'({vga_r, vga_g, vga_b}), 64'(vecs[i].exp_rgb));
      end
    end

    // One-cycle reset mid-frame while active pixels are in flight.
    layer_color = 48'h7E1_7E1_7E1_7E1;
    layer_transparent = 4'b0000;
    wait_beam(15, 8, ok);
    if (ok) begin
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid_rst_beam", 64'({beam_x, beam_y}), 64'd0);
      check("mid_rst_frame_start", 64'(frame_start), 64'd1);
      check("mid_rst_rgb0", 64'({vga_r, vga_g, vga_b}), 64'd0);
      check("mid_rst_sync", 64'({vga_hs, vga_vs, vga_hs2, vga_vs2}), 64'b0011);
      @(negedge clk);
      check("mid_rst_rgb1", 64'({vga_r, vga_g, vga_b}), 64'd0);
      check("mid_rst_beam1", 64'({beam_x, beam_y, frame_start}), 64'({11'd1, 10'd0, 1'b0}));
      @(negedge clk);
      check("mid_rst_rgb2", 64'({vga_r, vga_g, vga_b}), 64'h7E1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter H_VISIBLE, default 800: active pixels per line.
REQ-002 Parameter H_FRONT, default 56: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 120: horizontal sync width, in pixels.
REQ-004 Parameter H_BACK, default 64: horizontal back porch, in pixels.
REQ-005 Parameter V_VISIBLE, default 600: active lines per frame.
REQ-006 Parameter V_FRONT, default 37: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 6: vertical sync width, in lines.
REQ-008 Parameter V_BACK, default 23: vertical back porch, in lines.
REQ-009 Parameter SYNC_POL, default 1: sync asserted level.
REQ-010 Parameter N_LAYERS, default 4: number of overlay layers; index 0 is topmost.
REQ-011 Parameter BG_COLOR, default 12'hFFF: 12-bit {R,G,B} drawn when every layer is transparent.
REQ-012 clk  in  1  pixel clock; one pixel per cycle.
REQ-013 rst  in  1  reset; synchronous, active-high.
REQ-014 beam_x  out  11  current column, range 0..H_total-1.
REQ-015 beam_y  out  10  current line, range 0..V_total-1.
REQ-016 layer_color  in  N_LAYERS x [2:0][3:0]  per-layer {R,G,B} nibbles, index [2]=R, [1]=G, [0]=B.
REQ-017 layer_transparent  in  N_LAYERS  per-layer transparency; 1 means the layer does not cover the pixel.
REQ-018 vga_r, vga_g, vga_b  out  4 each  pixel colour.
REQ-019 vga_hs, vga_vs  out  1 each  sync outputs.
REQ-020 frame_start  out  1  one-cycle pulse at the first cycle of beam (0,0).

Function
REQ-021 H_total = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_total = V_VISIBLE+V_FRONT+V_SYNC+V_BACK.
REQ-022 beam_x is registered and increments by 1 per cycle; at H_total-1 it wraps to 0 and beam_y advances.
REQ-023 beam_y wraps from V_total-1 to 0 in the same cycle that beam_x wraps.
REQ-024 Active region: beam_x < H_VISIBLE and beam_y < V_VISIBLE.
REQ-025 Raw hsync = SYNC_POL when H_VISIBLE+H_FRONT <= beam_x < H_VISIBLE+H_FRONT+H_SYNC, else ~SYNC_POL.
REQ-026 Raw vsync uses the same rule on beam_y with the V parameters.
REQ-027 Layers drive layer_color/layer_transparent from registered logic: beam (x,y) presented in cycle t is answered in cycle t+1.
REQ-028 Cycle t+1: the compositor selects the lowest-index layer with transparent=0; if none, it selects BG_COLOR; the result is registered.
REQ-029 vga_r/g/b for beam (x,y) appear in cycle t+2.
REQ-030 vga_r/g/b = 0 whenever the delayed active flag is 0, regardless of layer inputs.
REQ-031 Active flag, raw hsync and raw vsync pass through a 2-stage delay so vga_hs/vga_vs/blanking align with vga_r/g/b.
REQ-032 frame_start is decoded combinationally from registered beam_x==0 && beam_y==0 and aligns with beam, not with the pixel outputs.
REQ-033 Layer inputs are sampled only in the compositor stage and have no other effect on timing.
REQ-034 The block contains no multipliers and no dividers.

Reset
REQ-035 While rst=1: beam_x=0, beam_y=0, both pipeline stages hold active=0 and sync=~SYNC_POL, vga_r/g/b=0, vga_hs=vga_vs=~SYNC_POL.
REQ-036 On the first cycle after rst deasserts, beam reads (0,0) and frame_start=1.
REQ-037 rst asserted mid-line or mid-frame takes effect on the next clock edge; the scan restarts from (0,0) with no partial-pixel output.

Verification
REQ-038 Release reset, run 1040*666 cycles -> exactly one frame_start per frame; beam_x wraps at 1039 and beam_y wraps at 665.
REQ-039 Count sync per line and frame -> vga_hs=1 for exactly 120 cycles per line starting at delayed x=856; vga_vs=1 for 6 lines starting at line 637.
REQ-040 Layer0 transparent, layer1={F,0,0} opaque, layer2={0,F,0} opaque, stimulated at beam (10,10) -> vga={F,0,0} two cycles later.
REQ-041 All layers transparent at (5,5) -> vga=BG_COLOR (F,F,F); same stimulus at beam_x=900 -> vga=0.
REQ-042 Assert rst for 1 cycle at beam (400,300) -> next cycle beam=(0,0) and frame_start=1; outputs stay 0 through the flushed 2-stage pipeline.
REQ-043 SYNC_POL=0 build -> sync idle level is 1 and pulses are low with identical widths.
